// File: rtl/riscv_lsu.sv
// riscv_lsu -- load/store unit between the core data port and data memory.
//
// One access per core request. The core is stalled from the request cycle
// until memory signals ready, then released for exactly one DONE cycle in
// which extended load data is presented.
//
// Ports
//   clk_i, rst_i        clock, asynchronous active-high reset
//   core_req_i          core requests an access (held stable while stalled)
//   core_we_i           1 = store, 0 = load
//   core_size_i         funct3: 0 B, 1 H, 2 W, 4 BU, 5 HU (others act as W)
//   core_addr_i         byte address
//   core_wd_i           store data
//   core_rd_o           extended load data, valid in DONE
//   core_stall_o        holds PC / RF write while the access is pending
//   mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wd_o   memory request
//   mem_rd_i, mem_ready_i                                 memory response
//
// Build option
//   RISCV_LSU_MISALIGN_EN  detect misaligned H/W accesses; they skip memory,
//                          complete immediately and pulse lsu_misalign_o.
module riscv_lsu #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              core_req_i,
  input  logic              core_we_i,
  input  logic [2:0]        core_size_i,
  input  logic [ADDR_W-1:0] core_addr_i,
  input  logic [DATA_W-1:0] core_wd_i,
  output logic [DATA_W-1:0] core_rd_o,
  output logic              core_stall_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [3:0]        mem_be_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wd_o,
  input  logic [DATA_W-1:0] mem_rd_i,
  input  logic              mem_ready_i
`ifdef RISCV_LSU_MISALIGN_EN
  ,
  output logic              lsu_misalign_o
`endif
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t            state, state_nxt;
  logic [DATA_W-1:0] rd_q;
  logic              is_b, is_h, is_u;
  logic              misalign;
  logic              active;
  logic [DATA_W-1:0] rd_sh;
  logic [7:0]        rd_byte;
  logic [15:0]       rd_half;

  // size decode: low two bits pick width, bit 2 marks unsigned loads
  assign is_b = (core_size_i[1:0] == 2'b00);
  assign is_h = (core_size_i[1:0] == 2'b01);
  assign is_u = core_size_i[2];

`ifdef RISCV_LSU_MISALIGN_EN
  assign misalign = (is_h & core_addr_i[0]) |
                    (!is_b & !is_h & (core_addr_i[1:0] != 2'b00));
`else
  assign misalign = 1'b0;
`endif

  // request is live outside DONE; reset gates it off immediately
  assign active       = core_req_i & (state != DONE) & !rst_i;
  assign core_stall_o = active;
  assign mem_req_o    = active & !misalign;

  assign mem_we_o   = core_we_i;
  assign mem_addr_o = core_addr_i;

  always_comb begin
    mem_be_o = 4'hF;
    mem_wd_o = core_wd_i;
    if (is_b) begin
      mem_be_o = 4'b0001 << core_addr_i[1:0];
      mem_wd_o = {4{core_wd_i[7:0]}};
    end else if (is_h) begin
      mem_be_o = 4'b0011 << {core_addr_i[1], 1'b0};
      mem_wd_o = {2{core_wd_i[15:0]}};
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (core_req_i) begin
        if (misalign || mem_ready_i) state_nxt = DONE;
        else                         state_nxt = BUSY;
      end
      // a request withdrawn mid-access is dropped without a DONE pulse
      BUSY: if (!core_req_i)      state_nxt = IDLE;
            else if (mem_ready_i) state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= IDLE;
      rd_q  <= '0;
    end else begin
      state <= state_nxt;
      if (mem_req_o && mem_ready_i && !core_we_i) rd_q <= mem_rd_i;
    end
  end

  // lane extraction from the captured word; address is still held in DONE
  assign rd_sh   = rd_q >> {core_addr_i[1:0], 3'b000};
  assign rd_byte = rd_sh[7:0];
  assign rd_half = core_addr_i[1] ? rd_q[31:16] : rd_q[15:0];

`ifdef RISCV_LSU_MISALIGN_EN
  assign lsu_misalign_o = (state == DONE) & core_req_i & misalign & !rst_i;
`endif

  always_comb begin
    core_rd_o = rd_q;
    if (is_b)      core_rd_o = {{24{rd_byte[7] & !is_u}}, rd_byte};
    else if (is_h) core_rd_o = {{16{rd_half[15] & !is_u}}, rd_half};
`ifdef RISCV_LSU_MISALIGN_EN
    if (lsu_misalign_o) core_rd_o = '0;
`endif
  end

endmodule

// File: tb/tb_riscv_lsu.sv
// Directed bench for riscv_lsu with a load-data scoreboard.
module tb_riscv_lsu;

  logic        clk, rst;
  logic        core_req, core_we;
  logic [2:0]  core_size;
  logic [31:0] core_addr, core_wd, core_rd;
  logic        core_stall, mem_req, mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr, mem_wd, mem_rd;
  logic        mem_ready;
`ifdef RISCV_LSU_MISALIGN_EN
  logic        lsu_misalign;
`endif

  int checks = 0;
  int errors = 0;
  logic [31:0] sb[$];

  riscv_lsu #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk_i(clk), .rst_i(rst),
    .core_req_i(core_req), .core_we_i(core_we), .core_size_i(core_size),
    .core_addr_i(core_addr), .core_wd_i(core_wd), .core_rd_o(core_rd),
    .core_stall_o(core_stall), .mem_req_o(mem_req), .mem_we_o(mem_we),
    .mem_be_o(mem_be), .mem_addr_o(mem_addr), .mem_wd_o(mem_wd),
    .mem_rd_i(mem_rd), .mem_ready_i(mem_ready)
`ifdef RISCV_LSU_MISALIGN_EN
    , .lsu_misalign_o(lsu_misalign)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Runs one access from just after a clock edge until just after the edge
  // that ends its DONE cycle. Memory raises ready after `waits` wait cycles.
  task automatic access(input string tag, input logic we, input logic [2:0] size,
                        input logic [31:0] addr, input logic [31:0] wd,
                        input logic [31:0] rdata, input int waits,
                        input logic [3:0] exp_be, input logic [31:0] exp_wd,
                        input logic [31:0] exp_rd, input logic exp_mis);
    int c, stall_n, req_n, exp_stall, exp_req;
    bit done;
    logic [31:0] e;
    core_req = 1'b1; core_we = we; core_size = size; core_addr = addr;
    core_wd = wd; mem_rd = rdata; mem_ready = (waits == 0);
    if (!we) sb.push_back(exp_rd);
    exp_stall = exp_mis ? 1 : waits + 1;
    exp_req   = exp_mis ? 0 : waits + 1;
    c = 0; stall_n = 0; req_n = 0; done = 0;
    while (!done && c < 40) begin
      @(negedge clk);
      if (c == 0) begin
        check({tag, " be"}, {28'b0, mem_be}, {28'b0, exp_be});
        check({tag, " wd"}, mem_wd, exp_wd);
        check({tag, " addr"}, mem_addr, addr);
        check({tag, " we"}, {31'b0, mem_we}, {31'b0, we});
      end
      if (core_stall) begin
        stall_n++;
        if (mem_req) req_n++;
        c++;
        @(posedge clk); #1;
        mem_ready = (c == waits);
      end else begin
        done = 1;
        check({tag, " done_req"}, {31'b0, mem_req}, 32'd0);
`ifdef RISCV_LSU_MISALIGN_EN
        check({tag, " misalign"}, {31'b0, lsu_misalign}, {31'b0, exp_mis});
`endif
        if (!we) begin
          if (sb.size() == 0) check({tag, " sb_empty"}, 32'd1, 32'd0);
          else begin
            e = sb.pop_front();
            check({tag, " rd"}, core_rd, e);
          end
        end
      end
    end
    if (!done) check({tag, " timeout"}, 32'd0, 32'd1);
    check({tag, " stall_cycles"}, stall_n, exp_stall);
    check({tag, " req_cycles"}, req_n, exp_req);
    @(posedge clk); #1;
    mem_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1; core_req = 1'b0; core_we = 1'b0; core_size = 3'd2;
    core_addr = '0; core_wd = '0; mem_rd = '0; mem_ready = 1'b0;
    #12;
    check("rst stall", {31'b0, core_stall}, 32'd0);
    check("rst req",   {31'b0, mem_req},    32'd0);
    check("rst rd",    core_rd,             32'd0);
    @(posedge clk); #1; rst = 1'b0;
    @(posedge clk); #1;

    access("sb",    1'b1, 3'd0, 32'h1003, 32'h0000_00A5, 32'h0, 0, 4'b1000, 32'hA5A5_A5A5, 32'h0, 1'b0);
    core_req = 1'b0; @(posedge clk); #1;
    access("lb",    1'b0, 3'd0, 32'h1002, 32'h0, 32'h0080_0000, 0, 4'b0100, 32'h0, 32'hFFFF_FF80, 1'b0);
    core_req = 1'b0; @(posedge clk); #1;
    access("lbu",   1'b0, 3'd4, 32'h1002, 32'h0, 32'h0080_0000, 0, 4'b0100, 32'h0, 32'h0000_0080, 1'b0);
    access("lh_w3", 1'b0, 3'd1, 32'h2002, 32'h0, 32'hBEEF_1234, 3, 4'b1100, 32'h0, 32'hFFFF_BEEF, 1'b0);
    access("lhu",   1'b0, 3'd5, 32'h2000, 32'h0, 32'h1234_8765, 1, 4'b0011, 32'h0, 32'h0000_8765, 1'b0);
    access("sh_w2", 1'b1, 3'd1, 32'h2002, 32'h0000_CAFE, 32'h0, 2, 4'b1100, 32'hCAFE_CAFE, 32'h0, 1'b0);
    core_req = 1'b0; @(posedge clk); #1;

    // back-to-back: request held high across the boundary
    access("b2b_sw", 1'b1, 3'd2, 32'h40, 32'hDEAD_BEEF, 32'h0, 0, 4'hF, 32'hDEAD_BEEF, 32'h0, 1'b0);
    access("b2b_lw", 1'b0, 3'd2, 32'h44, 32'h0, 32'h1234_5678, 0, 4'hF, 32'h0, 32'h1234_5678, 1'b0);

    // ready while idle must not capture data or raise a request
    core_req = 1'b0; mem_ready = 1'b1; mem_rd = 32'hFFFF_FFFF;
    @(negedge clk);
    check("idle_ready req", {31'b0, mem_req}, 32'd0);
    @(posedge clk); #1; @(negedge clk);
    check("idle_ready rd", core_rd, 32'h1234_5678);
    @(posedge clk); #1; mem_ready = 1'b0;

    access("lw_sz3", 1'b0, 3'd3, 32'h48, 32'h0, 32'h89AB_CDEF, 0, 4'hF, 32'h0, 32'h89AB_CDEF, 1'b0);
    access("lb_pos", 1'b0, 3'd0, 32'h1001, 32'h0, 32'h0000_7F00, 2, 4'b0010, 32'h0, 32'h0000_007F, 1'b0);

    // request withdrawn while BUSY, then a fresh access
    core_req = 1'b1; core_we = 1'b0; core_size = 3'd2; core_addr = 32'h60; mem_ready = 1'b0;
    @(posedge clk); #1; @(posedge clk); #1;
    core_req = 1'b0;
    @(negedge clk);
    check("drop stall", {31'b0, core_stall}, 32'd0);
    @(posedge clk); #1;
    access("after_drop", 1'b0, 3'd2, 32'h60, 32'h0, 32'h0BAD_F00D, 1, 4'hF, 32'h0, 32'h0BAD_F00D, 1'b0);

    // reset in BUSY abandons the access and clears captured data
    core_req = 1'b1; core_we = 1'b0; core_size = 3'd2; core_addr = 32'h50;
    mem_rd = 32'h1111_1111; mem_ready = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    check("busy stall", {31'b0, core_stall}, 32'd1);
    check("busy req",   {31'b0, mem_req},    32'd1);
    #2 rst = 1'b1;
    #1;
    check("midrst req",   {31'b0, mem_req},    32'd0);
    check("midrst stall", {31'b0, core_stall}, 32'd0);
    check("midrst rd",    core_rd,             32'd0);
    @(posedge clk); #1; rst = 1'b0;
    access("post_rst", 1'b0, 3'd2, 32'h50, 32'h0, 32'h1111_1111, 0, 4'hF, 32'h0, 32'h1111_1111, 1'b0);

`ifdef RISCV_LSU_MISALIGN_EN
    access("lw_mis", 1'b0, 3'd2, 32'h3001, 32'h0, 32'h5555_5555, 0, 4'hF, 32'h0, 32'h0, 1'b1);
`else
    access("lh_odd", 1'b0, 3'd1, 32'h2001, 32'h0, 32'hAAAA_F00D, 0, 4'b0011, 32'h0, 32'hFFFF_F00D, 1'b0);
`endif
    core_req = 1'b0;
    @(posedge clk); #1;
    check("sb_drained", sb.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
